// File: rtl/sha256_padder.sv
// Word-serial FIPS 180-4 message padder feeding a SHA-256 core.
// Passes message words through, then appends the 0x80 marker, zero fill and 64-bit bit length.
module sha256_padder #(
   parameter int LEN_BITS = 32
) (
   input  logic          C,
   input  logic          R,
   input  logic [0:31]   IN_WORD,
   input  logic          IN_VALID,
   input  logic          IN_LAST,
   input  logic [0:1]    IN_BYTES,
   output logic          IN_READY,
   output logic [0:31]   BLK_WORD,
   output logic [3:0]    BLK_IDX,
   output logic          BLK_VALID,
   output logic          BLK_FIRST,
   output logic          BLK_LAST,
   input  logic          BLK_READY
);

   typedef enum logic [2:0] {
      S_DATA,
      S_MARK,
      S_ZERO,
      S_LENH,
      S_LENL
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [LEN_BITS-1:0] r_bitCount;
   logic [LEN_BITS-1:0] w_nextCount;
   logic [3:0]          r_nextIdx;
   logic                r_firstPending;
   logic [0:31]         r_word;
   logic [3:0]          r_idx;
   logic                r_valid;
   logic                r_first;
   logic                r_last;
   logic [0:31]         w_loadWord;
   logic                w_empty;
   logic                w_accept;
   logic                w_load;
   logic [63:0]         w_len64;
   logic [3:0]          w_idxAfter;

   // The output stage can take a new word when it is empty or being drained this cycle.
   assign w_empty    = !r_valid || BLK_READY;
   assign IN_READY   = (r_state == S_DATA) && w_empty;
   assign w_accept   = IN_VALID && IN_READY;
   assign w_load     = (r_state == S_DATA) ? w_accept : w_empty;
   assign w_len64    = 64'(r_bitCount);
   assign w_idxAfter = r_nextIdx + 4'd1;

   assign BLK_WORD  = r_word;
   assign BLK_IDX   = r_idx;
   assign BLK_VALID = r_valid;
   assign BLK_FIRST = r_first;
   assign BLK_LAST  = r_last;

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         r_state <= S_DATA;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_bitCount;
      w_loadWord  = 32'h0;
      case (r_state)
         S_DATA: begin
            w_loadWord = IN_WORD;
            if (w_accept) begin
               if (!IN_LAST || IN_BYTES == 2'd0) begin
                  w_nextCount = r_bitCount + LEN_BITS'(32);
                  if (IN_LAST) begin
                     w_nextState = S_MARK;
                  end
               end else begin
                  // Partial final word: the marker lives inside it, so no separate MARK word.
                  w_nextCount = r_bitCount + LEN_BITS'({IN_BYTES, 3'b000});
                  case (IN_BYTES)
                     2'd1:    w_loadWord = {IN_WORD[0:7], 8'h80, 16'h0000};
                     2'd2:    w_loadWord = {IN_WORD[0:15], 8'h80, 8'h00};
                     default: w_loadWord = {IN_WORD[0:23], 8'h80};
                  endcase
                  w_nextState = (r_nextIdx == 4'd13) ? S_LENH : S_ZERO;
               end
            end
         end
         S_MARK, S_ZERO: begin
            w_loadWord = (r_state == S_MARK) ? 32'h8000_0000 : 32'h0;
            if (w_load) begin
               w_nextState = (w_idxAfter == 4'd14) ? S_LENH : S_ZERO;
            end
         end
         S_LENH: begin
            w_loadWord = w_len64[63:32];
            if (w_load) begin
               w_nextState = S_LENL;
            end
         end
         S_LENL: begin
            w_loadWord = w_len64[31:0];
            if (w_load) begin
               w_nextState = S_DATA;
               w_nextCount = '0;
            end
         end
         default: begin
            w_nextState = S_DATA;
         end
      endcase
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         r_bitCount     <= '0;
         r_nextIdx      <= 4'd0;
         r_firstPending <= 1'b1;
         r_word         <= 32'h0;
         r_idx          <= 4'd0;
         r_valid        <= 1'b0;
         r_first        <= 1'b0;
         r_last         <= 1'b0;
      end else begin
         r_bitCount <= w_nextCount;
         if (w_empty) begin
            r_valid <= w_load;
         end
         if (w_load) begin
            r_word    <= w_loadWord;
            r_idx     <= r_nextIdx;
            r_nextIdx <= w_idxAfter;
            r_first   <= r_firstPending && (r_state == S_DATA);
            r_last    <= (r_state == S_LENL);
            // FIRST belongs to the first data word of each message.
            if (r_state == S_DATA) begin
               r_firstPending <= 1'b0;
            end
            if (r_state == S_LENL) begin
               r_firstPending <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: table-driven messages, random messages,
// backpressure hold checks and a mid-message reset, all against a byte-level padding model.
module tb_sha256_padder;

   logic        clk;
   logic        rstN;
   logic [31:0] inWord;
   logic        inValid;
   logic        inLast;
   logic [1:0]  inBytes;
   logic        inReady;
   logic [31:0] blkWord;
   logic [3:0]  blkIdx;
   logic        blkValid;
   logic        blkFirst;
   logic        blkLast;
   logic        blkReady;

   typedef struct {
      int          nWords;
      int          lastBytes;
      bit          stress;
      bit          abc;
      int          expTotal;
      logic [31:0] expLenLo;
   } vector_t;

   vector_t     vectors[10];
   logic [31:0] msgWords[$];
   logic [31:0] gotWord[$];
   logic [3:0]  gotIdx[$];
   logic        gotFirst[$];
   logic        gotLast[$];
   logic [31:0] expWord[$];
   logic [3:0]  expIdx[$];
   logic        expFirst[$];
   logic        expLast[$];
   int          tests;
   int          failures;

   sha256_padder #(.LEN_BITS(32)) dut (
      .C         (clk),
      .R         (rstN),
      .IN_WORD   (inWord),
      .IN_VALID  (inValid),
      .IN_LAST   (inLast),
      .IN_BYTES  (inBytes),
      .IN_READY  (inReady),
      .BLK_WORD  (blkWord),
      .BLK_IDX   (blkIdx),
      .BLK_VALID (blkValid),
      .BLK_FIRST (blkFirst),
      .BLK_LAST  (blkLast),
      .BLK_READY (blkReady)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: pad the message as a byte string, then cut it into words.
   task automatic buildExpected(input int lastBytes);
      byte unsigned bytes[$];
      logic [63:0]  bitLen;
      logic [31:0]  w;
      int           nOut;
      expWord.delete();
      expIdx.delete();
      expFirst.delete();
      expLast.delete();
      for (int k = 0; k < msgWords.size(); k++) begin
         int take;
         take = (k == msgWords.size() - 1 && lastBytes != 0) ? lastBytes : 4;
         w = msgWords[k];
         for (int b = 0; b < take; b++) bytes.push_back(w[31 - 8 * b -: 8]);
      end
      bitLen = {32'h0, 32'(bytes.size() * 8)};
      bytes.push_back(8'h80);
      while (bytes.size() % 64 != 56) bytes.push_back(8'h00);
      for (int b = 0; b < 8; b++) bytes.push_back(bitLen[63 - 8 * b -: 8]);
      nOut = bytes.size() / 4;
      for (int k = 0; k < nOut; k++) begin
         expWord.push_back({bytes[4 * k], bytes[4 * k + 1], bytes[4 * k + 2], bytes[4 * k + 3]});
         expIdx.push_back(4'(k % 16));
         expFirst.push_back(k == 0);
         expLast.push_back(k == nOut - 1);
      end
   endtask

   // Drives msgWords in, collects output words until BLK_LAST, and checks stalled outputs hold.
   task automatic applyStimulus(input int lastBytes, input bit stress);
      int          ptr;
      int          cyc;
      bit          done;
      bit          holdValid;
      logic [38:0] held;
      ptr = 0;
      cyc = 0;
      done = 0;
      holdValid = 0;
      held = '0;
      gotWord.delete();
      gotIdx.delete();
      gotFirst.delete();
      gotLast.delete();
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         blkReady = stress ? (cyc % 2 == 1) : 1'b1;
         if (ptr < msgWords.size()) begin
            inValid = stress ? 1'($urandom_range(0, 1)) : 1'b1;
            inWord  = msgWords[ptr];
            inLast  = (ptr == msgWords.size() - 1);
            inBytes = inLast ? 2'(lastBytes) : 2'($urandom_range(0, 3));
         end else begin
            inValid = 1'b0;
            inLast  = 1'b0;
         end
         #1;
         if (holdValid) begin
            checkOutput("stall hold", {25'h0, blkValid, blkFirst, blkLast, blkIdx, blkWord}, {25'h0, held});
         end
         holdValid = blkValid && !blkReady;
         held = {blkValid, blkFirst, blkLast, blkIdx, blkWord};
         if (blkValid && blkReady) begin
            gotWord.push_back(blkWord);
            gotIdx.push_back(blkIdx);
            gotFirst.push_back(blkFirst);
            gotLast.push_back(blkLast);
            if (blkLast) done = 1;
         end
         if (inValid && inReady) ptr++;
      end
      inValid = 1'b0;
      inLast  = 1'b0;
      if (!done) begin
         failures++;
         tests++;
         $display("[TB] FAIL timeout: got %0d words, expected BLK_LAST", gotWord.size());
      end
   endtask

   // Compares the collected output stream word by word against the model.
   task automatic compareStream(input string tag);
      int n;
      checkOutput({tag, " count"}, 64'(gotWord.size()), 64'(expWord.size()));
      n = (gotWord.size() < expWord.size()) ? gotWord.size() : expWord.size();
      for (int k = 0; k < n; k++) begin
         checkOutput($sformatf("%s word%0d", tag, k),
                     {26'h0, gotFirst[k], gotLast[k], gotIdx[k], gotWord[k]},
                     {26'h0, expFirst[k], expLast[k], expIdx[k], expWord[k]});
      end
   endtask

   // Main sequence: reset checks, vector table, random messages, mid-message reset.
   initial begin
      int ptr;
      int cyc;
      int nw;
      int lb;
      tests = 0;
      failures = 0;
      rstN = 1'b0;
      inWord = '0;
      inValid = 1'b0;
      inLast = 1'b0;
      inBytes = '0;
      blkReady = 1'b1;

      vectors[0] = '{1, 3, 1'b0, 1'b1, 16, 32'h0000_0018};
      vectors[1] = '{13, 0, 1'b0, 1'b0, 16, 32'h0000_01A0};
      vectors[2] = '{14, 0, 1'b0, 1'b0, 32, 32'h0000_01C0};
      vectors[3] = '{16, 0, 1'b0, 1'b0, 32, 32'h0000_0200};
      vectors[4] = '{1, 3, 1'b1, 1'b1, 16, 32'h0000_0018};
      vectors[5] = '{14, 3, 1'b0, 1'b0, 16, 32'h0000_01B8};
      vectors[6] = '{1, 1, 1'b0, 1'b0, 16, 32'h0000_0008};
      vectors[7] = '{15, 0, 1'b0, 1'b0, 32, 32'h0000_01E0};
      vectors[8] = '{14, 2, 1'b1, 1'b0, 16, 32'h0000_01B0};
      vectors[9] = '{20, 1, 1'b1, 1'b0, 32, 32'h0000_0268};

      repeat (3) @(negedge clk);
      checkOutput("reset BLK_VALID", 64'(blkValid), 64'd0);
      checkOutput("reset BLK_WORD", 64'(blkWord), 64'd0);
      checkOutput("reset BLK_IDX", 64'(blkIdx), 64'd0);
      checkOutput("reset BLK_FIRST/LAST", {62'h0, blkFirst, blkLast}, 64'd0);
      checkOutput("reset IN_READY", 64'(inReady), 64'd1);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("post-reset IN_READY", 64'(inReady), 64'd1);

      for (int v = 0; v < 10; v++) begin
         msgWords.delete();
         for (int k = 0; k < vectors[v].nWords; k++) begin
            msgWords.push_back(vectors[v].abc ? 32'h6162_6300 : $urandom);
         end
         applyStimulus(vectors[v].lastBytes, vectors[v].stress);
         buildExpected(vectors[v].lastBytes);
         compareStream($sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0d total", v), 64'(gotWord.size()), 64'(vectors[v].expTotal));
         if (gotWord.size() > 0) begin
            checkOutput($sformatf("vec%0d length", v), 64'(gotWord[gotWord.size() - 1]), 64'(vectors[v].expLenLo));
         end
         if (vectors[v].abc && gotWord.size() > 0) begin
            checkOutput($sformatf("vec%0d abc word0", v), 64'(gotWord[0]), 64'h6162_6380);
         end
      end

      for (int r = 0; r < 6; r++) begin
         nw = $urandom_range(1, 36);
         lb = $urandom_range(0, 3);
         msgWords.delete();
         for (int k = 0; k < nw; k++) msgWords.push_back($urandom);
         applyStimulus(lb, 1'($urandom_range(0, 1)));
         buildExpected(lb);
         compareStream($sformatf("rand%0d", r));
      end

      msgWords.delete();
      for (int k = 0; k < 10; k++) msgWords.push_back($urandom);
      ptr = 0;
      cyc = 0;
      blkReady = 1'b1;
      while (ptr < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         inValid = 1'b1;
         inWord  = msgWords[ptr];
         inLast  = 1'b0;
         #1;
         if (inReady) ptr++;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("mid-message BLK_VALID", 64'(blkValid), 64'd1);
      rstN = 1'b0;
      #1;
      checkOutput("reset drop BLK_VALID", 64'(blkValid), 64'd0);
      checkOutput("reset drop BLK_IDX", 64'(blkIdx), 64'd0);
      checkOutput("reset drop IN_READY", 64'(inReady), 64'd1);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      msgWords.delete();
      msgWords.push_back(32'h6162_6300);
      applyStimulus(3, 1'b0);
      buildExpected(3);
      compareStream("after reset");
      if (gotWord.size() > 0) begin
         checkOutput("after reset length", 64'(gotWord[gotWord.size() - 1]), 64'h18);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
